// File: rtl/cnn_seq_pkg.sv
// Shared definitions for the CNN multi-pass sequencer: FSM state encoding and
// the loopback FIFO address-width helper.
package cnn_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PSUM_LOAD,
    S_START,
    S_RUN,
    S_NEXT,
    S_DONE
  } seq_state_e;

  function automatic int unsigned loop_aw(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_loop_fifo.sv
// First-word-fall-through loopback FIFO holding one pass worth of results,
// replayed as partial sums on the following pass.
module seq_loop_fifo
  import cnn_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = loop_aw(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so push is legal even when full.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cnn_pass_sequencer.sv
// Multi-pass layer scheduler: streams ifmap/filter words into the CNN, starts it,
// drains results either back as partial sums (loopback FIFO) or to the output sink.
module cnn_pass_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int unsigned IFMAP_BUFFER_WIDTH  = 8,
  parameter int unsigned FILTER_BUFFER_WIDTH = 8,
  parameter int unsigned RESULT_BUFFER_WIDTH = 8,
  parameter int unsigned CNT_W               = 10,
  parameter int unsigned PASS_W              = 4,
  parameter int unsigned LOOP_DEPTH          = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_start,
  input  logic [PASS_W-1:0]              cfg_num_passes,
  input  logic [CNT_W-1:0]               cfg_if_words,
  input  logic [CNT_W-1:0]               cfg_filter_words,
  input  logic [CNT_W-1:0]               cfg_result_words,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [PASS_W-1:0]              pass_idx,
  input  logic [IFMAP_BUFFER_WIDTH-1:0]  src_if_data,
  input  logic                           src_if_valid,
  output logic                           src_if_ready,
  input  logic [FILTER_BUFFER_WIDTH-1:0] src_filter_data,
  input  logic                           src_filter_valid,
  output logic                           src_filter_ready,
  output logic [RESULT_BUFFER_WIDTH-1:0] snk_data,
  output logic                           snk_valid,
  input  logic                           snk_ready,
  output logic                           cnn_start,
  output logic                           cnn_psum_mode,
  output logic [IFMAP_BUFFER_WIDTH-1:0]  cnn_if_wdata,
  output logic                           cnn_if_wen,
  input  logic                           cnn_if_full,
  output logic [FILTER_BUFFER_WIDTH-1:0] cnn_filter_wdata,
  output logic                           cnn_filter_wen,
  input  logic                           cnn_filter_full,
  output logic [RESULT_BUFFER_WIDTH-1:0] cnn_psum_wdata,
  output logic                           cnn_psum_wen,
  input  logic                           cnn_psum_ready,
  input  logic [RESULT_BUFFER_WIDTH-1:0] cnn_result_data,
  output logic                           cnn_result_ren,
  input  logic                           cnn_result_empty,
  input  logic                           cnn_result_valid
);

  seq_state_e state, state_d;

  logic [CNT_W-1:0]  if_words_q, filter_words_q, result_words_q;
  logic [CNT_W-1:0]  if_cnt, filter_cnt, psum_cnt, res_cnt;
  logic [PASS_W-1:0] num_passes_q;
  logic [PASS_W:0]   pass_next_w;
  logic              rd_pending;

  logic fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [RESULT_BUFFER_WIDTH-1:0] fifo_rdata;

  logic final_pass, dest_ok, cfg_oversize;
  logic cfg_accept, err_set, cnt_clear, pass_inc, res_accept;

  assign pass_next_w  = {1'b0, pass_idx} + (PASS_W+1)'(1);
  assign final_pass   = (pass_next_w == {1'b0, num_passes_q});
  assign cfg_oversize = (32'(cfg_result_words) > LOOP_DEPTH);

  always_comb begin
    state_d          = state;
    src_if_ready     = 1'b0;
    src_filter_ready = 1'b0;
    cnn_if_wen       = 1'b0;
    cnn_if_wdata     = '0;
    cnn_filter_wen   = 1'b0;
    cnn_filter_wdata = '0;
    cnn_psum_wen     = 1'b0;
    cnn_psum_wdata   = '0;
    cnn_start        = 1'b0;
    cnn_result_ren   = 1'b0;
    snk_valid        = 1'b0;
    snk_data         = '0;
    done             = 1'b0;
    dest_ok          = 1'b0;
    fifo_push        = 1'b0;
    fifo_pop         = 1'b0;
    cfg_accept       = 1'b0;
    err_set          = 1'b0;
    cnt_clear        = 1'b0;
    pass_inc         = 1'b0;
    res_accept       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (cfg_start) begin
          if (cfg_oversize) begin
            err_set = 1'b1;
          end else begin
            cfg_accept = 1'b1;
            state_d    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        src_if_ready     = !cnn_if_full && (if_cnt < if_words_q);
        src_filter_ready = !cnn_filter_full && (filter_cnt < filter_words_q);
        cnn_if_wen       = src_if_valid && src_if_ready;
        cnn_if_wdata     = cnn_if_wen ? src_if_data : '0;
        cnn_filter_wen   = src_filter_valid && src_filter_ready;
        cnn_filter_wdata = cnn_filter_wen ? src_filter_data : '0;
        if ((if_cnt >= if_words_q) && (filter_cnt >= filter_words_q))
          state_d = (pass_idx != '0) ? S_PSUM_LOAD : S_START;
      end
      S_PSUM_LOAD: begin
        if (psum_cnt >= result_words_q) begin
          state_d = S_START;
        end else if (fifo_empty) begin
          err_set = 1'b1;
          state_d = S_DONE;
        end else if (cnn_psum_ready) begin
          cnn_psum_wen   = 1'b1;
          cnn_psum_wdata = fifo_rdata;
          fifo_pop       = 1'b1;
        end
      end
      S_START: begin
        cnn_start = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        dest_ok        = final_pass ? snk_ready : !fifo_full;
        cnn_result_ren = !cnn_result_empty && !rd_pending &&
                         (res_cnt < result_words_q) && dest_ok;
        if (cnn_result_valid) begin
          if (rd_pending) begin
            res_accept = 1'b1;
            if (final_pass) begin
              snk_valid = 1'b1;
              snk_data  = cnn_result_data;
            end else begin
              fifo_push = 1'b1;
            end
          end else begin
            err_set = 1'b1;
          end
        end
        // Leave on the accepting beat itself; the final pass skips NEXT so that
        // done follows the last sink beat directly (NEXT would only end the layer).
        if (res_cnt >= result_words_q)
          state_d = S_NEXT;
        else if (res_accept && ((res_cnt + CNT_W'(1)) == result_words_q))
          state_d = final_pass ? S_DONE : S_NEXT;
      end
      S_NEXT: begin
        cnt_clear = 1'b1;
        pass_inc  = !final_pass;
        state_d   = final_pass ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state != S_IDLE) && (state != S_DONE);
  assign cnn_psum_mode = (pass_idx != '0) &&
                         ((state == S_LOAD) || (state == S_PSUM_LOAD) ||
                          (state == S_START) || (state == S_RUN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      error          <= 1'b0;
      pass_idx       <= '0;
      num_passes_q   <= '0;
      if_words_q     <= '0;
      filter_words_q <= '0;
      result_words_q <= '0;
      if_cnt         <= '0;
      filter_cnt     <= '0;
      psum_cnt       <= '0;
      res_cnt        <= '0;
      rd_pending     <= 1'b0;
    end else begin
      state <= state_d;
      if (err_set)         error <= 1'b1;
      else if (cfg_accept) error <= 1'b0;

      if (cfg_accept) begin
        num_passes_q   <= (cfg_num_passes == '0) ? PASS_W'(1) : cfg_num_passes;
        if_words_q     <= cfg_if_words;
        filter_words_q <= cfg_filter_words;
        result_words_q <= cfg_result_words;
        pass_idx       <= '0;
        if_cnt         <= '0;
        filter_cnt     <= '0;
        psum_cnt       <= '0;
        res_cnt        <= '0;
        rd_pending     <= 1'b0;
      end else begin
        if (cnt_clear) begin
          if_cnt     <= '0;
          filter_cnt <= '0;
          psum_cnt   <= '0;
          res_cnt    <= '0;
        end else begin
          if (cnn_if_wen)     if_cnt     <= if_cnt + CNT_W'(1);
          if (cnn_filter_wen) filter_cnt <= filter_cnt + CNT_W'(1);
          if (cnn_psum_wen)   psum_cnt   <= psum_cnt + CNT_W'(1);
          if (res_accept)     res_cnt    <= res_cnt + CNT_W'(1);
        end
        if (pass_inc) pass_idx <= pass_idx + PASS_W'(1);
        if (cnn_result_ren)  rd_pending <= 1'b1;
        else if (res_accept) rd_pending <= 1'b0;
      end
    end
  end

  seq_loop_fifo #(
    .WIDTH (RESULT_BUFFER_WIDTH),
    .DEPTH (LOOP_DEPTH)
  ) u_loop_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr       (cfg_accept),
    .push      (fifo_push),
    .push_data (cnn_result_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
